// File: rtl/synth_pkg.sv
// Shared types, constants and note arithmetic for the polyphonic note allocator.
package synth_pkg;

    localparam int MIDI_NOTE_MAX = 127;
    localparam logic [3:0] MAJOR_OFFSETS [7] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd7, 4'd9, 4'd11};

    typedef logic [7:0] note_t;
    typedef logic [2:0] rank_t;
    typedef logic [2:0] voice_idx_t;
    typedef logic [4:0] key_idx_t;

    // Full-width signed arithmetic so negative octave shifts clamp rather than wrap.
    function automatic note_t calc_note(input int base, input key_idx_t key,
                                        input logic major, input logic signed [2:0] octave);
        int         off;
        int         n;
        logic [2:0] deg;
        deg = 3'(int'(key) % 7);
        if (major)
            off = 12 * (int'(key) / 7) + int'(MAJOR_OFFSETS[deg]);
        else
            off = int'(key);
        n = base + off + 12 * int'(octave);
        if (n < 0)
            return '0;
        else if (n > MIDI_NOTE_MAX)
            return note_t'(MIDI_NOTE_MAX);
        else
            return note_t'(n);
    endfunction

endpackage

// File: rtl/voice_rank_tracker.sv
// Age ranks of the voice slots: rank 0 = most recently allocated, NUM_VOICES-1 = oldest.
module voice_rank_tracker
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alloc,
    input  voice_idx_t alloc_voice,
    output voice_idx_t oldest_voice
);

    rank_t ranks [NUM_VOICES];
    rank_t sel_rank;

    always_comb begin
        sel_rank     = '0;
        oldest_voice = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (alloc_voice == voice_idx_t'(v))
                sel_rank = ranks[v];
            if (ranks[v] == rank_t'(NUM_VOICES - 1))
                oldest_voice = voice_idx_t'(v);
        end
    end

    // Only voices younger than the chosen one age, which keeps ranks a permutation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VOICES; v++)
                ranks[v] <= rank_t'(v);
        end else if (alloc) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (alloc_voice == voice_idx_t'(v))
                    ranks[v] <= '0;
                else if (ranks[v] < sel_rank)
                    ranks[v] <= ranks[v] + 3'd1;
            end
        end
    end

endmodule

// File: rtl/poly_note_allocator.sv
// Polyphonic key-to-voice allocator: queues key edges, services one per cycle,
// assigns free voices lowest-first and steals the oldest voice when all are busy.
module poly_note_allocator
    import synth_pkg::*;
#(
    parameter int NUM_KEYS   = 16,
    parameter int NUM_VOICES = 4,
    parameter int BASE_NOTE  = 60
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_KEYS-1:0]     key_in,
    input  logic                    scale_mode_in,
    input  logic [2:0]              octave_in,
    output logic [8*NUM_VOICES-1:0] note_out,
    output logic [NUM_VOICES-1:0]   gate_out,
    output logic [NUM_VOICES-1:0]   trigger_out,
    output logic                    steal_out
);

    logic [NUM_KEYS-1:0]   key_prev, pending_on, pending_off;
    logic [NUM_KEYS-1:0]   on_next, off_next, rise, fall;
    key_idx_t              owners [NUM_VOICES];
    note_t                 notes  [NUM_VOICES];
    logic                  svc_off, svc_on, all_gated, free_found;
    key_idx_t              off_key, on_key;
    voice_idx_t            free_voice, oldest_voice, alloc_voice;
    logic [NUM_VOICES-1:0] rel_mask, alloc_mask;
    note_t                 new_note;

    assign rise = key_in & ~key_prev;
    assign fall = ~key_in & key_prev;

    // Releases always take priority over presses; lowest key index wins within a class.
    always_comb begin
        svc_off = |pending_off;
        svc_on  = !svc_off && (|pending_on);
        off_key = '0;
        on_key  = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (pending_off[k]) off_key = key_idx_t'(k);
            if (pending_on[k])  on_key  = key_idx_t'(k);
        end
    end

    always_comb begin
        rel_mask   = '0;
        free_found = 1'b0;
        free_voice = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (svc_off && gate_out[v] && owners[v] == off_key && rel_mask == '0)
                rel_mask[v] = 1'b1;
            if (!gate_out[v] && !free_found) begin
                free_found = 1'b1;
                free_voice = voice_idx_t'(v);
            end
        end
        all_gated   = !free_found;
        alloc_voice = all_gated ? oldest_voice : free_voice;
        for (int v = 0; v < NUM_VOICES; v++)
            alloc_mask[v] = svc_on && (alloc_voice == voice_idx_t'(v));
        new_note = calc_note(BASE_NOTE, on_key, scale_mode_in, octave_in);
    end

    // A fall that catches its own unserviced press cancels the press entirely.
    always_comb begin
        on_next  = pending_on;
        off_next = pending_off;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (svc_off && off_key == key_idx_t'(k)) off_next[k] = 1'b0;
            if (svc_on  && on_key  == key_idx_t'(k)) on_next[k]  = 1'b0;
            if (rise[k]) begin
                on_next[k] = 1'b1;
            end else if (fall[k]) begin
                if (on_next[k]) begin
                    on_next[k]  = 1'b0;
                    off_next[k] = 1'b0;
                end else begin
                    off_next[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            key_prev    <= '0;
            pending_on  <= '0;
            pending_off <= '0;
            gate_out    <= '0;
            trigger_out <= '0;
            steal_out   <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                owners[v] <= '0;
                notes[v]  <= '0;
            end
        end else begin
            key_prev    <= key_in;
            pending_on  <= on_next;
            pending_off <= off_next;
            trigger_out <= alloc_mask;
            steal_out   <= svc_on && all_gated;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (rel_mask[v])
                    gate_out[v] <= 1'b0;
                if (alloc_mask[v]) begin
                    gate_out[v] <= 1'b1;
                    owners[v]   <= on_key;
                    notes[v]    <= new_note;
                end
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_note
        assign note_out[8*v +: 8] = notes[v];
    end

    voice_rank_tracker #(.NUM_VOICES(NUM_VOICES)) u_rank (
        .clk          (clk_in),
        .rst          (rst_in),
        .alloc        (svc_on),
        .alloc_voice  (alloc_voice),
        .oldest_voice (oldest_voice)
    );

endmodule

// File: tb/tb_poly_note_allocator.sv
// Directed bench for poly_note_allocator with an event-queue reference model.
module tb_poly_note_allocator;

    localparam int NK = 16;
    localparam int NV = 4;
    localparam int BASE = 60;

    logic            clk = 1'b0;
    logic            rst_in;
    logic [NK-1:0]   key_in;
    logic            scale_mode_in;
    logic [2:0]      octave_in;
    logic [8*NV-1:0] note_out;
    logic [NV-1:0]   gate_out;
    logic [NV-1:0]   trigger_out;
    logic            steal_out;

    int errors = 0;
    int checks = 0;

    poly_note_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .BASE_NOTE(BASE)) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .key_in        (key_in),
        .scale_mode_in (scale_mode_in),
        .octave_in     (octave_in),
        .note_out      (note_out),
        .gate_out      (gate_out),
        .trigger_out   (trigger_out),
        .steal_out     (steal_out)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Voice age is kept as a list ordered oldest-first rather than numeric ranks.
    bit m_prev [NK];
    bit m_pon  [NK];
    bit m_poff [NK];
    int m_owner[NV];
    bit m_gate [NV];
    int m_note [NV];
    bit m_trig [NV];
    bit m_steal;
    int m_age[$];
    bit model_live = 1'b0;
    int m_ksel, m_vsel, m_oct;
    int maj_tab [7] = '{0, 2, 4, 5, 7, 9, 11};

    function automatic int model_note(input int k, input bit major, input int oct);
        int n;
        n = BASE + (major ? 12 * (k / 7) + maj_tab[k % 7] : k) + 12 * oct;
        if (n < 0) n = 0;
        if (n > 127) n = 127;
        return n;
    endfunction

    always @(posedge clk) begin
        model_live = 1'b1;
        if (rst_in) begin
            for (int k = 0; k < NK; k++) begin
                m_prev[k] = 0; m_pon[k] = 0; m_poff[k] = 0;
            end
            for (int v = 0; v < NV; v++) begin
                m_owner[v] = 0; m_gate[v] = 0; m_note[v] = 0; m_trig[v] = 0;
            end
            m_steal = 0;
            m_age.delete();
            for (int v = NV - 1; v >= 0; v--) m_age.push_back(v);
        end else begin
            for (int v = 0; v < NV; v++) m_trig[v] = 0;
            m_steal = 0;
            m_ksel = -1;
            for (int k = 0; k < NK; k++) if (m_poff[k] && m_ksel < 0) m_ksel = k;
            if (m_ksel >= 0) begin
                m_poff[m_ksel] = 0;
                for (int v = 0; v < NV; v++)
                    if (m_gate[v] && m_owner[v] == m_ksel) m_gate[v] = 0;
            end else begin
                for (int k = 0; k < NK; k++) if (m_pon[k] && m_ksel < 0) m_ksel = k;
                if (m_ksel >= 0) begin
                    m_pon[m_ksel] = 0;
                    m_vsel = -1;
                    for (int v = 0; v < NV; v++) if (!m_gate[v] && m_vsel < 0) m_vsel = v;
                    if (m_vsel < 0) begin
                        m_vsel = m_age[0];
                        m_steal = 1;
                    end
                    for (int i = 0; i < m_age.size(); i++)
                        if (m_age[i] == m_vsel) begin m_age.delete(i); break; end
                    m_age.push_back(m_vsel);
                    m_oct = $signed(octave_in);
                    m_owner[m_vsel] = m_ksel;
                    m_gate[m_vsel]  = 1;
                    m_note[m_vsel]  = model_note(m_ksel, scale_mode_in, m_oct);
                    m_trig[m_vsel]  = 1;
                end
            end
            for (int k = 0; k < NK; k++) begin
                if (key_in[k] && !m_prev[k]) m_pon[k] = 1;
                else if (!key_in[k] && m_prev[k]) begin
                    if (m_pon[k]) begin m_pon[k] = 0; m_poff[k] = 0; end
                    else m_poff[k] = 1;
                end
                m_prev[k] = key_in[k];
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            for (int v = 0; v < NV; v++) begin
                chk($sformatf("model gate[%0d]", v), int'(gate_out[v]), int'(m_gate[v]));
                chk($sformatf("model trig[%0d]", v), int'(trigger_out[v]), int'(m_trig[v]));
                chk($sformatf("model note[%0d]", v), int'(note_out[8*v +: 8]), m_note[v]);
            end
            chk("model steal", int'(steal_out), int'(m_steal));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int vnote(input int v);
        return int'(note_out[8*v +: 8]);
    endfunction

    // ---------------- directed stimulus ----------------
    initial begin
        rst_in = 1'b1; key_in = '0; scale_mode_in = 1'b0; octave_in = 3'd0;
        wait_cyc(3);
        chk("reset gate", int'(gate_out), 0);
        chk("reset note", int'(note_out), 0);
        chk("reset trig", int'(trigger_out), 0);
        chk("reset steal", int'(steal_out), 0);
        rst_in = 1'b0;
        wait_cyc(2);

        // Basic press/release, chromatic octave 0
        key_in = 16'h0010;
        wait_cyc(2);
        chk("k4 gate", int'(gate_out), 1);
        chk("k4 note", vnote(0), 64);
        chk("k4 trig", int'(trigger_out), 1);
        wait_cyc(1);
        chk("k4 trig width", int'(trigger_out), 0);
        key_in = 16'h0000;
        wait_cyc(2);
        chk("k4 release gate", int'(gate_out), 0);
        chk("k4 release note", vnote(0), 64);

        // Note mapping
        scale_mode_in = 1'b1; octave_in = 3'b001;
        key_in = 16'h0100;
        wait_cyc(2);
        chk("major k8 oct+1", vnote(0), 86);
        key_in = 16'h0000;
        wait_cyc(2);
        octave_in = 3'b100;
        key_in = 16'h0001;
        wait_cyc(2);
        chk("major k0 oct-4", vnote(0), 12);
        octave_in = 3'b001;
        wait_cyc(1);
        chk("note held under octave change", vnote(0), 12);
        key_in = 16'h0000;
        wait_cyc(2);
        scale_mode_in = 1'b0; octave_in = 3'b011;
        key_in = 16'h8000;
        wait_cyc(2);
        chk("chrom k15 oct+3", vnote(0), 111);
        key_in = 16'h0000;
        octave_in = 3'b000;
        wait_cyc(2);

        // Fill all voices then steal the oldest
        key_in = 16'h0001; wait_cyc(1);
        key_in = 16'h0003; wait_cyc(1);
        key_in = 16'h0007; wait_cyc(1);
        key_in = 16'h000F; wait_cyc(1);
        key_in = 16'h002F;
        wait_cyc(2);
        chk("steal note v0", vnote(0), 65);
        chk("steal trig", int'(trigger_out), 1);
        chk("steal pulse", int'(steal_out), 1);
        chk("steal gates", int'(gate_out), 15);
        wait_cyc(1);
        chk("steal pulse width", int'(steal_out), 0);
        key_in = 16'h002E;
        wait_cyc(2);
        chk("stolen key release gates", int'(gate_out), 15);
        chk("stolen key release note", vnote(0), 65);
        key_in = 16'h0000;
        wait_cyc(6);
        chk("all released", int'(gate_out), 0);

        // Simultaneous presses serviced on consecutive cycles
        key_in = 16'h0084;
        wait_cyc(2);
        chk("k2 first gate", int'(gate_out), 1);
        chk("k2 first note", vnote(0), 62);
        wait_cyc(1);
        chk("k7 second gate", int'(gate_out), 3);
        chk("k7 second note", vnote(1), 67);
        chk("k7 second trig", int'(trigger_out), 2);
        key_in = 16'h0000;
        wait_cyc(4);

        // Press cancelled while queued behind another press
        key_in = 16'h0009;
        wait_cyc(1);
        key_in = 16'h0001;
        wait_cyc(1);
        chk("k0 ahead gate", int'(gate_out), 1);
        wait_cyc(2);
        chk("k3 cancelled gate", int'(gate_out), 1);
        chk("k3 cancelled trig", int'(trigger_out), 0);
        key_in = 16'h0000;
        wait_cyc(3);

        // Reset mid-operation with keys held
        key_in = 16'h0242;
        wait_cyc(5);
        chk("pre-reset gates", int'(gate_out), 7);
        rst_in = 1'b1;
        key_in = 16'h0042;
        wait_cyc(1);
        chk("mid reset gate", int'(gate_out), 0);
        chk("mid reset note", int'(note_out), 0);
        chk("mid reset trig", int'(trigger_out), 0);
        wait_cyc(1);
        rst_in = 1'b0;
        wait_cyc(2);
        chk("post reset k1 gate", int'(gate_out), 1);
        chk("post reset k1 note", vnote(0), 61);
        wait_cyc(1);
        chk("post reset k6 gate", int'(gate_out), 3);
        chk("post reset k6 note", vnote(1), 66);
        key_in = 16'h0000;
        wait_cyc(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
